hack_memory: RTL and testbench
==============================

Name: hack_memory

Overview:
- Data-memory map of the Hack CPU: one 16-bit data bus, decoded by a 15-bit address into three regions.
  - 16K-word RAM at 0–16383.
  - 8K-word screen buffer at 16384–24575.
  - Read-only keyboard register at 24576.
- Sits between the CPU data port (in/load/address/out) and the display/keyboard peripherals.
- Reads are combinational; writes are clocked.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 15, CPU address width.
- KBD_ADDR, 24576, keyboard register address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  16  write data.
- load  input  1  write enable; write occurs on the rising clk edge while load=1.
- address  input  15  word address.
- out  output  16  read data for the current address (combinational).
- kbd_in  input  16  raw scan code from the keyboard peripheral.

Behaviour:
- Decode:
  - address[14]=0: RAM16K, index address[13:0].
  - address[14:13]=2'b10: screen, index address[12:0].
  - address==24576: keyboard.
  - 24577–32767: unmapped.
- Internal nets named out_ram16k, out_ram8k, out_keyboard carry each region's read data. They are probed hierarchically by benches and must exist under these names.
- Read:
  - out is driven combinationally from the region selected by the current address; zero cycle latency.
  - Unmapped addresses return 16'h0000.
- Write, at posedge clk with load=1:
  - Only the selected RAM16K or screen word is written with in.
  - Writes to the keyboard address or to unmapped addresses are ignored.
  - No other location changes.
- Read-during-write, same address: out shows the old word until the edge and the new word after it. No write-through bypass.
- Keyboard path:
  - kbd_in is registered into kbd_q every clk.
  - out_keyboard = kbd_q, giving one cycle of latency from kbd_in.
- Reset:
  - rst=1 at a clock edge clears kbd_q to 0. Keyboard reads return 0 during reset and for the cycle after release.
  - RAM16K and screen contents are not cleared, so they map to block RAM. Contents are undefined (X) until first written.
  - A write with load=1 during rst=1 still takes effect.
- Memory contents need no initialization file.

Optional Feature:
- Macro SCREEN_RD_PORT_EN.
- Defined:
  - Adds input scr_addr[12:0] and output scr_data[15:0].
  - scr_data is a registered second read port of the screen buffer: one-cycle latency, reset to 0, for the display controller.
  - A simultaneous CPU write to the same word returns the old data on scr_data.
- Undefined: the ports are absent and the screen is accessible only via the CPU port. CPU-side behaviour is identical in both builds.

Test Plan:
- load=1, in=FFFF, address=75, one edge; then load=0, address=75 -> out=FFFF and out_ram16k=FFFF.
- load=1, in=FFFF, address=24000, one edge; then load=0, address=24000 -> out=FFFF. Also check address 16384+0 is unaffected.
- kbd_in=0, load=1, in=FFFF, address=24576, edge; then load=0, address=24576 -> out=0000, because the write is ignored. Then kbd_in=0x0041 -> out=0041 one cycle later.
- rst=1 for one edge with kbd_in=0x0020 held -> out at 24576 = 0000 during reset and the following cycle, then 0020.
- Write 1234 to address 16383 and 5678 to address 16384 -> each reads back its own value; no aliasing between the RAM16K/screen boundary words.
- address=30000, load=1, in=ABCD, edge -> out=0000. Addresses 75 and 24000 keep their previous values.

Source files
------------

// File: rtl/hack_memory.sv
// Hack CPU data-memory map: 16K RAM, 8K screen buffer and a registered keyboard word on one bus.
// Optional SCREEN_RD_PORT_EN adds a registered screen read port for the display controller.
module hack_memory #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int KBD_ADDR = 24576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] kbd_in
`ifdef SCREEN_RD_PORT_EN
  ,
  input  logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_data
`endif
);

  localparam int RAM_WORDS = 16384;
  localparam int SCR_WORDS = 8192;

  logic [DATA_W-1:0] ram16k_mem [RAM_WORDS];
  logic [DATA_W-1:0] screen_mem [SCR_WORDS];
  logic [DATA_W-1:0] kbd_q;

  logic [DATA_W-1:0] out_ram16k;
  logic [DATA_W-1:0] out_ram8k;
  logic [DATA_W-1:0] out_keyboard;

  logic        sel_ram;
  logic        sel_scr;
  logic        sel_kbd;
  logic [13:0] ram_idx;
  logic [12:0] scr_idx;

  assign sel_ram = ~address[ADDR_W-1];
  assign sel_scr = (address[ADDR_W-1:ADDR_W-2] == 2'b10);
  assign sel_kbd = (address == ADDR_W'(KBD_ADDR));
  assign ram_idx = address[13:0];
  assign scr_idx = address[12:0];

  // Writes are not gated by rst so both arrays can map onto plain block RAM.
  always_ff @(posedge clk) begin
    if (load && sel_ram) ram16k_mem[ram_idx] <= in;
  end

  always_ff @(posedge clk) begin
    if (load && sel_scr) screen_mem[scr_idx] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) kbd_q <= '0;
    else     kbd_q <= kbd_in;
  end

  assign out_ram16k   = ram16k_mem[ram_idx];
  assign out_ram8k    = screen_mem[scr_idx];
  assign out_keyboard = kbd_q;

  always_comb begin
    out = '0;
    if (sel_ram)      out = out_ram16k;
    else if (sel_scr) out = out_ram8k;
    else if (sel_kbd) out = out_keyboard;
  end

`ifdef SCREEN_RD_PORT_EN
  // Non-blocking read alongside the CPU write gives old-data on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst) scr_data <= '0;
    else     scr_data <= screen_mem[scr_addr];
  end
`endif

endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory: directed map checks then randomized traffic against a sparse word model.
// Exercises the SCREEN_RD_PORT_EN port as well when that macro is defined.
module tb_hack_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [14:0] address;
  logic [15:0] out;
  logic [15:0] kbd_in;
`ifdef SCREEN_RD_PORT_EN
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mdl [int];
  logic [15:0] kbd_m;
`ifdef SCREEN_RD_PORT_EN
  logic [15:0] scr_m;
  bit          scr_known;
`endif

  hack_memory dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out),
    .kbd_in  (kbd_in)
`ifdef SCREEN_RD_PORT_EN
    ,
    .scr_addr(scr_addr),
    .scr_data(scr_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge; the model applies the memory-map rules to the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
`ifdef SCREEN_RD_PORT_EN
    if (rst) begin
      scr_m = 16'h0000; scr_known = 1'b1;
    end else if (mdl.exists(16384 + int'(scr_addr))) begin
      scr_m = mdl[16384 + int'(scr_addr)]; scr_known = 1'b1;
    end else begin
      scr_known = 1'b0;
    end
`endif
    kbd_m = rst ? 16'h0000 : kbd_in;
    if (load && int'(address) < 24576) mdl[int'(address)] = in;
    #1;
  endtask

  function automatic bit exp_out(input int a, output logic [15:0] v);
    v = 16'h0000;
    if (a < 24576) begin
      if (!mdl.exists(a)) return 1'b0;
      v = mdl[a];
    end else if (a == 24576) begin
      v = kbd_m;
    end
    return 1'b1;
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    address = 15'(a); in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input logic [15:0] exp);
    address = 15'(a);
    #1;
    chk(tag, out, exp);
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 11))
      0:  return 0;
      1:  return 75;
      2:  return 16383;
      3:  return 16384;
      4:  return 24000;
      5:  return 24575;
      6:  return 24576;
      7:  return 24577;
      8:  return 30000;
      9:  return 32767;
      10: return int'($urandom_range(0, 16383));
      default: return int'($urandom_range(16384, 16400));
    endcase
  endfunction

  initial begin
    logic [15:0] v;
    int a;
    rst = 1'b1; load = 1'b0; in = '0; address = '0; kbd_in = 16'h1234;
`ifdef SCREEN_RD_PORT_EN
    scr_addr = '0;
`endif
    step(); step();
    rd("reset_kbd", 24576, 16'h0000);
`ifdef SCREEN_RD_PORT_EN
    chk("reset_scr", scr_data, 16'h0000);
`endif
    rst = 1'b0; kbd_in = 16'h0000;

    wr(75, 16'hFFFF);
    rd("ram_75", 75, 16'hFFFF);
    chk("probe_ram16k", dut.out_ram16k, 16'hFFFF);

    wr(16384, 16'h0F0F);
    wr(24000, 16'hFFFF);
    rd("scr_24000", 24000, 16'hFFFF);
    chk("probe_ram8k", dut.out_ram8k, 16'hFFFF);
    rd("scr_base_kept", 16384, 16'h0F0F);

    wr(24576, 16'hFFFF);
    rd("kbd_wr_ignored", 24576, 16'h0000);
    kbd_in = 16'h0041;
    rd("kbd_before_edge", 24576, 16'h0000);
    step();
    rd("kbd_latency", 24576, 16'h0041);
    chk("probe_kbd", dut.out_keyboard, 16'h0041);

    rst = 1'b1; kbd_in = 16'h0020;
    step();
    rd("kbd_in_reset", 24576, 16'h0000);
    rst = 1'b0;
    rd("kbd_after_release", 24576, 16'h0000);
    step();
    rd("kbd_resumed", 24576, 16'h0020);

    wr(16383, 16'h1234);
    wr(16384, 16'h5678);
    rd("bound_16383", 16383, 16'h1234);
    rd("bound_16384", 16384, 16'h5678);

    wr(30000, 16'hABCD);
    rd("unmapped_30000", 30000, 16'h0000);
    rd("kept_75", 75, 16'hFFFF);
    rd("kept_24000", 24000, 16'hFFFF);
    rd("kept_16384", 16384, 16'h5678);

    // Same-address read-during-write: old word before the edge, new one after.
    address = 15'd75; in = 16'h00AA; load = 1'b1;
    #1;
    chk("rdw_old", out, 16'hFFFF);
    step();
    load = 1'b0;
    chk("rdw_new", out, 16'h00AA);

    for (int i = 0; i < 600; i++) begin
      a = pick_addr();
      address = 15'(a);
      in      = 16'($urandom);
      load    = ($urandom_range(0, 1) == 1);
      kbd_in  = 16'($urandom);
      rst     = ($urandom_range(0, 24) == 0);
`ifdef SCREEN_RD_PORT_EN
      scr_addr = 13'($urandom_range(0, 16));
`endif
      #1;
      if (exp_out(a, v)) chk("rand_pre", out, v);
      step();
      if (exp_out(a, v)) chk("rand_post", out, v);
`ifdef SCREEN_RD_PORT_EN
      if (scr_known) chk("rand_scr", scr_data, scr_m);
`endif
      load = 1'b0;
      a = pick_addr();
      address = 15'(a);
      #1;
      if (exp_out(a, v)) chk("rand_read", out, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
